// File: rtl/cc_mpc_sequencer.sv
// Microprogram sequencer: owns the MPC, the PSR condition flags and the
// RUN/WAIT/HALT control that stalls on data memory and stops at HALT_ADDRESS.
module cc_mpc_sequencer #(
  parameter int DATAWIDTH_BUS = 11,
  parameter int DATAWIDTH_MUX_SELECTION = 2,
  parameter logic [DATAWIDTH_BUS-1:0] HALT_ADDRESS = 11'h7FF
) (
  input  logic                               CC_MPC_CLOCK_50,
  input  logic                               CC_MPC_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]           CC_MPC_Address_InBUS,
  input  logic [2:0]                         CC_MPC_Cond_InBUS,
  input  logic                               CC_MPC_IR13_In,
  input  logic [3:0]                         CC_MPC_Flags_InBUS,
  input  logic                               CC_MPC_SetCC_In,
  input  logic                               CC_MPC_MemReq_In,
  input  logic                               CC_MPC_MemAck_In,
  output logic [DATAWIDTH_BUS-1:0]           CC_MPC_Address_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_MPC_Next_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] CC_MPC_Selection_OutBUS,
  output logic [3:0]                         CC_MPC_PSR_OutBUS,
  output logic                               CC_MPC_Wait_Out,
  output logic                               CC_MPC_Halt_Out
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } seqState_t;

  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] SEL_NEXT   = DATAWIDTH_MUX_SELECTION'(0);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] SEL_JUMP   = DATAWIDTH_MUX_SELECTION'(1);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] SEL_DECODE = DATAWIDTH_MUX_SELECTION'(2);

  seqState_t stateReg, stateNext;
  logic [DATAWIDTH_BUS-1:0] mpcReg;
  logic [3:0] psrReg;
  logic advance;
  logic loadsHalt;

  assign loadsHalt = (CC_MPC_Address_InBUS == HALT_ADDRESS);

  // Branch conditions test the registered PSR so a jump after a SetCC word sees its flags.
  always_comb begin
    CC_MPC_Selection_OutBUS = SEL_NEXT;
    case (CC_MPC_Cond_InBUS)
      3'd1: if (psrReg[3]) CC_MPC_Selection_OutBUS = SEL_JUMP;
      3'd2: if (psrReg[2]) CC_MPC_Selection_OutBUS = SEL_JUMP;
      3'd3: if (psrReg[1]) CC_MPC_Selection_OutBUS = SEL_JUMP;
      3'd4: if (psrReg[0]) CC_MPC_Selection_OutBUS = SEL_JUMP;
      3'd5: if (CC_MPC_IR13_In) CC_MPC_Selection_OutBUS = SEL_JUMP;
      3'd6: CC_MPC_Selection_OutBUS = SEL_JUMP;
      3'd7: CC_MPC_Selection_OutBUS = SEL_DECODE;
      default: CC_MPC_Selection_OutBUS = SEL_NEXT;
    endcase
  end

  always_comb begin
    stateNext = stateReg;
    advance = 1'b0;
    case (stateReg)
      RUN: begin
        if (CC_MPC_MemReq_In && !CC_MPC_MemAck_In) begin
          stateNext = WAIT;
        end else begin
          advance = 1'b1;
          stateNext = loadsHalt ? HALT : RUN;
        end
      end
      WAIT: begin
        if (CC_MPC_MemAck_In) begin
          advance = 1'b1;
          stateNext = loadsHalt ? HALT : RUN;
        end
      end
      HALT: stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge CC_MPC_CLOCK_50) begin
    if (!CC_MPC_RESET_InLow) begin
      stateReg <= RUN;
      mpcReg   <= '0;
      psrReg   <= '0;
    end else begin
      stateReg <= stateNext;
      if (advance) begin
        mpcReg <= CC_MPC_Address_InBUS;
        if (CC_MPC_SetCC_In) psrReg <= CC_MPC_Flags_InBUS;
      end
    end
  end

  assign CC_MPC_Address_OutBUS = mpcReg;
  assign CC_MPC_Next_OutBUS    = mpcReg + DATAWIDTH_BUS'(1);
  assign CC_MPC_PSR_OutBUS     = psrReg;
  assign CC_MPC_Wait_Out       = (stateReg == WAIT);
  assign CC_MPC_Halt_Out       = (stateReg == HALT);

endmodule

// File: tb/tb_cc_mpc_sequencer.sv
// Directed bench for cc_mpc_sequencer; the bench plays the microaddress mux
// (next / jump / decode) so the loop closes as it does in the control section.
module tb_cc_mpc_sequencer;

  logic clk = 1'b0;
  logic rstN;
  logic [10:0] addrIn;
  logic [2:0] cond;
  logic ir13;
  logic [3:0] flags;
  logic setCC, memReq, memAck;
  logic [10:0] mpc, nextAddr;
  logic [1:0] sel;
  logic [3:0] psr;
  logic waitOut, haltOut;
  logic [10:0] jumpAddr, decodeAddr;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  cc_mpc_sequencer dut (
    .CC_MPC_CLOCK_50(clk),
    .CC_MPC_RESET_InLow(rstN),
    .CC_MPC_Address_InBUS(addrIn),
    .CC_MPC_Cond_InBUS(cond),
    .CC_MPC_IR13_In(ir13),
    .CC_MPC_Flags_InBUS(flags),
    .CC_MPC_SetCC_In(setCC),
    .CC_MPC_MemReq_In(memReq),
    .CC_MPC_MemAck_In(memAck),
    .CC_MPC_Address_OutBUS(mpc),
    .CC_MPC_Next_OutBUS(nextAddr),
    .CC_MPC_Selection_OutBUS(sel),
    .CC_MPC_PSR_OutBUS(psr),
    .CC_MPC_Wait_Out(waitOut),
    .CC_MPC_Halt_Out(haltOut)
  );

  always_comb begin
    case (sel)
      2'b00:   addrIn = nextAddr;
      2'b01:   addrIn = jumpAddr;
      default: addrIn = decodeAddr;
    endcase
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; cond = 3'd0; ir13 = 1'b0; flags = 4'd0; setCC = 1'b0;
    memReq = 1'b0; memAck = 1'b0; jumpAddr = 11'h000; decodeAddr = 11'h555;
    tick();
    tick();
    checkVal("rst_mpc", 32'(mpc), 32'h0);
    checkVal("rst_psr", 32'(psr), 32'h0);
    checkVal("rst_wait", 32'(waitOut), 32'h0);
    checkVal("rst_halt", 32'(haltOut), 32'h0);
    checkVal("rst_next", 32'(nextAddr), 32'h1);
    checkVal("rst_sel", 32'(sel), 32'h0);
    rstN = 1'b1;

    // Free run through MPC+1
    tick(); checkVal("run_mpc1", 32'(mpc), 32'h1);
    tick(); checkVal("run_mpc2", 32'(mpc), 32'h2);
    setCC = 1'b1; flags = 4'b1010;
    tick(); checkVal("run_mpc3", 32'(mpc), 32'h3);
    checkVal("run_psr", 32'(psr), 32'ha);
    setCC = 1'b0; flags = 4'd0;
    rstN = 1'b0;
    tick(); checkVal("rerst_mpc", 32'(mpc), 32'h0);
    checkVal("rerst_psr", 32'(psr), 32'h0);
    rstN = 1'b1;

    // Conditional jumps on registered PSR
    setCC = 1'b1; flags = 4'b0100;
    tick(); checkVal("setz_mpc", 32'(mpc), 32'h1);
    checkVal("setz_psr", 32'(psr), 32'h4);
    setCC = 1'b0; flags = 4'b1111;
    cond = 3'd2; jumpAddr = 11'h120; #1;
    checkVal("c2_sel", 32'(sel), 32'h1);
    tick(); checkVal("c2_mpc", 32'(mpc), 32'h120);
    cond = 3'd1; #1;
    checkVal("c1_sel", 32'(sel), 32'h0);
    tick(); checkVal("c1_mpc", 32'(mpc), 32'h121);
    cond = 3'd3; #1; checkVal("c3_sel", 32'(sel), 32'h0);
    cond = 3'd4; #1; checkVal("c4_sel", 32'(sel), 32'h0);
    cond = 3'd6; #1; checkVal("c6_sel", 32'(sel), 32'h1);
    cond = 3'd7; #1; checkVal("c7_sel", 32'(sel), 32'h2);
    tick(); checkVal("c7_mpc", 32'(mpc), 32'h555);
    cond = 3'd5; ir13 = 1'b1; #1; checkVal("c5_ir1_sel", 32'(sel), 32'h1);
    ir13 = 1'b0; #1; checkVal("c5_ir0_sel", 32'(sel), 32'h0);
    flags = 4'd0;

    // Memory wait, ack after 3 cycles
    cond = 3'd6; jumpAddr = 11'h010;
    tick(); checkVal("mw_start", 32'(mpc), 32'h010);
    cond = 3'd0; memReq = 1'b1; memAck = 1'b0; setCC = 1'b1; flags = 4'b0011;
    tick(); checkVal("mw_wait1", 32'(waitOut), 32'h1);
    checkVal("mw_mpc1", 32'(mpc), 32'h010);
    checkVal("mw_psr1", 32'(psr), 32'h4);
    tick(); checkVal("mw_wait2", 32'(waitOut), 32'h1);
    tick(); checkVal("mw_wait3", 32'(waitOut), 32'h1);
    checkVal("mw_mpc3", 32'(mpc), 32'h010);
    checkVal("mw_psr3", 32'(psr), 32'h4);
    memAck = 1'b1;
    tick(); checkVal("mw_done_wait", 32'(waitOut), 32'h0);
    checkVal("mw_done_mpc", 32'(mpc), 32'h011);
    checkVal("mw_done_psr", 32'(psr), 32'h3);
    setCC = 1'b0; flags = 4'd0;

    // Immediate ack: no WAIT
    memReq = 1'b1; memAck = 1'b1;
    tick(); checkVal("imm_wait", 32'(waitOut), 32'h0);
    checkVal("imm_mpc", 32'(mpc), 32'h012);
    memReq = 1'b0; memAck = 1'b0;

    // Halt and freeze
    cond = 3'd6; jumpAddr = 11'h7FF;
    tick(); checkVal("halt_flag", 32'(haltOut), 32'h1);
    checkVal("halt_mpc", 32'(mpc), 32'h7FF);
    checkVal("halt_next", 32'(nextAddr), 32'h000);
    for (int i = 0; i < 10; i++) begin
      cond = 3'($urandom_range(7)); memReq = 1'($urandom_range(1));
      memAck = 1'($urandom_range(1)); flags = 4'($urandom_range(15)); setCC = 1'b1;
      jumpAddr = 11'h100;
      tick(); checkVal($sformatf("halt_hold_mpc%0d", i), 32'(mpc), 32'h7FF);
      checkVal($sformatf("halt_hold_psr%0d", i), 32'(psr), 32'h3);
      checkVal($sformatf("halt_hold_flag%0d", i), 32'(haltOut), 32'h1);
    end
    memReq = 1'b0; memAck = 1'b0; setCC = 1'b0; flags = 4'd0; cond = 3'd0;
    rstN = 1'b0;
    tick(); checkVal("halt_rst_flag", 32'(haltOut), 32'h0);
    checkVal("halt_rst_mpc", 32'(mpc), 32'h0);
    checkVal("halt_rst_psr", 32'(psr), 32'h0);
    rstN = 1'b1;

    // Wrap-around: 0x7FE + 1 halts
    cond = 3'd6; jumpAddr = 11'h7FE;
    tick(); checkVal("wrap_mpc", 32'(mpc), 32'h7FE);
    cond = 3'd0; #1;
    checkVal("wrap_next", 32'(nextAddr), 32'h7FF);
    tick(); checkVal("wrap_halt", 32'(haltOut), 32'h1);
    checkVal("wrap_halt_mpc", 32'(mpc), 32'h7FF);
    rstN = 1'b0;
    tick(); rstN = 1'b1;

    // Reset during WAIT
    tick(); checkVal("rw_pre_mpc", 32'(mpc), 32'h1);
    memReq = 1'b1; memAck = 1'b0;
    tick(); checkVal("rw_wait", 32'(waitOut), 32'h1);
    rstN = 1'b0;
    tick(); checkVal("rw_rst_wait", 32'(waitOut), 32'h0);
    checkVal("rw_rst_mpc", 32'(mpc), 32'h0);
    rstN = 1'b1; memReq = 1'b0;
    tick(); checkVal("rw_run_mpc", 32'(mpc), 32'h1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
